// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states and
// the request legality check used at grant time.
package dmem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Reserved size or a misaligned half/word; the range check lives in the top.
    function automatic logic size_align_err(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_H:   bad = off[0];
            SIZE_W:   bad = |off;
            SIZE_RSV: bad = 1'b1;
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the memory port and requesters: extracts and
// extends load values, and merges sub-word store data into a read word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_mem_rd,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0] w_b [4];
    logic [7:0] w_m [4];
    logic [7:0] w_lo;
    logic [7:0] w_hi;

    // Memory read order is reversed: byte (base+k) sits in the top lanes first.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_b[k] = i_mem_rd[31 - 8 * k -: 8];
        end
    end

    always_comb begin
        w_lo = w_b[i_offset];
        w_hi = w_b[i_offset + 2'd1];
        case (i_size)
            SIZE_B:  o_load = {{24{i_signed & w_lo[7]}}, w_lo};
            SIZE_H:  o_load = {{16{i_signed & w_hi[7]}}, w_hi, w_lo};
            default: o_load = {w_b[3], w_b[2], w_b[1], w_b[0]};
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_m[k] = w_b[k];
            if ((i_size == SIZE_B || i_size == SIZE_H) && 2'(k) == i_offset) begin
                w_m[k] = i_wdata[7:0];
            end
            if (i_size == SIZE_H && 2'(k) == i_offset + 2'd1) begin
                w_m[k] = i_wdata[15:8];
            end
        end
        o_merge = {w_m[3], w_m[2], w_m[1], w_m[0]};
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the single-port
// data memory; sub-word stores are done as read-modify-write.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_signed,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic        m1_signed,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic [1:0]  o_dbg_state
);

    state_t      r_state;
    logic        r_rr_last;
    logic        r_owner;
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wd;
    logic        r_mem_we;

    logic        w_any;
    logic        w_grant;
    logic        w_ack;
    logic        w_we;
    logic        w_signed;
    logic        w_err;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Only one requester: it wins. Both: the one not granted last time.
    assign w_any   = m0_req | m1_req;
    assign w_grant = (m0_req && m1_req) ? ~r_rr_last : m1_req;
    assign w_ack   = rst_n && (r_state == ST_IDLE) && w_any;

    assign w_we     = w_grant ? m1_we     : m0_we;
    assign w_size   = w_grant ? m1_size   : m0_size;
    assign w_signed = w_grant ? m1_signed : m0_signed;
    assign w_addr   = w_grant ? m1_addr   : m0_addr;
    assign w_wdata  = w_grant ? m1_wdata  : m0_wdata;
    assign w_err    = size_align_err(w_size, w_addr[1:0]) || (w_addr >= 32'(MEM_BYTES));

    dmem_lane_align u_align (
        .i_mem_rd (mem_rd),
        .i_offset (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_last  <= 1'b1;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= SIZE_B;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_mem_we   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_rr_last <= w_grant;
                        r_owner   <= w_grant;
                        r_we      <= w_we;
                        r_signed  <= w_signed;
                        r_size    <= w_size;
                        r_off     <= w_addr[1:0];
                        r_wdata   <= w_wdata[15:0];
                        if (w_err) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (!w_we || w_size != SIZE_W) begin
                            r_mem_addr <= {w_addr[31:2], 2'b00};
                            r_state    <= ST_RD;
                        end else begin
                            r_mem_addr <= {w_addr[31:2], 2'b00};
                            r_mem_wd   <= w_wdata;
                            r_mem_we   <= 1'b1;
                            r_state    <= ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (!r_we) begin
                        r_rdata    <= w_load;
                        r_done     <= 1'b1;
                        r_mem_addr <= '0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_mem_wd <= w_merge;
                        r_mem_we <= 1'b1;
                        r_state  <= ST_WR;
                    end
                end
                ST_WR: begin
                    r_done     <= 1'b1;
                    r_mem_addr <= '0;
                    r_mem_wd   <= '0;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m0_ack   = w_ack & ~w_grant;
    assign m1_ack   = w_ack & w_grant;
    assign m0_done  = r_done & ~r_owner;
    assign m1_done  = r_done & r_owner;
    assign m0_err   = r_err & ~r_owner;
    assign m1_err   = r_err & r_owner;
    assign m0_rdata = r_owner ? 32'd0 : r_rdata;
    assign m1_rdata = r_owner ? r_rdata : 32'd0;

    assign mem_addr    = r_mem_addr;
    assign mem_wd      = r_mem_wd;
    assign mem_we      = r_mem_we;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory model, table of single accesses,
// round-robin sequence and reset-during-write sequence.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req, m0_we, m0_signed, m1_req, m1_we, m1_signed;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_done, m0_err, m1_ack, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic preload = 1'b1;
    logic [7:0] tb_mem [256];
    logic [33:0] exp_q [$];

    typedef struct {
        logic        mst;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [$];

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_signed(m0_signed),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_done(m0_done),
        .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_signed(m1_signed),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_done(m1_done),
        .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: reads in reversed byte order, writes in natural order.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i);
            tb_mem[0] <= 8'h11; tb_mem[1] <= 8'h22; tb_mem[2] <= 8'h33; tb_mem[3] <= 8'h44;
            tb_mem[4] <= 8'h80; tb_mem[5] <= 8'hFF; tb_mem[6] <= 8'h7F; tb_mem[7] <= 8'h01;
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) tb_mem[mem_addr[7:0] + 8'(k)] <= mem_wd[8 * k +: 8];
        end
    end

    always_comb begin
        mem_rd = {tb_mem[mem_addr[7:0]], tb_mem[mem_addr[7:0] + 8'd1],
                  tb_mem[mem_addr[7:0] + 8'd2], tb_mem[mem_addr[7:0] + 8'd3]};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mst, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input logic [31:0] rdata, input logic [31:0] wd);
        vec_t v;
        v.mst = mst; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_err = err; v.exp_rdata = rdata; v.exp_wd = wd;
        if (err) v.exp_lat = 1;
        else if (we && size != SIZE_W) v.exp_lat = 3;
        else v.exp_lat = 2;
        return v;
    endfunction

    task automatic set_req(input logic mst, input logic req, input vec_t v);
        if (!mst) begin
            m0_req = req; m0_we = v.we; m0_size = v.size; m0_signed = v.sgn;
            m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_req = req; m1_we = v.we; m1_size = v.size; m1_signed = v.sgn;
            m1_addr = v.addr; m1_wdata = v.wdata;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name, output int n_wait);
        int t_ack, we_cnt;
        logic got;
        logic [31:0] wd;
        logic [33:0] e;
        @(posedge clk); #1;
        set_req(v.mst, 1'b1, v);
        got = 1'b0;
        n_wait = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (v.mst ? m1_ack : m0_ack) got = 1'b1;
            else n_wait++;
        end
        chk($sformatf("%s ack", name), got, 1);
        chk($sformatf("%s other ack", name), v.mst ? m0_ack : m1_ack, 0);
        t_ack = cyc;
        if (got) exp_q.push_back({v.mst, v.exp_err, v.exp_rdata});
        @(posedge clk); #1;
        set_req(v.mst, 1'b0, v);
        we_cnt = 0; wd = '0;
        for (int i = 0; i < 10 && got; i++) begin
            @(negedge clk);
            if (mem_we) begin we_cnt++; wd = mem_wd; end
            if (m0_done || m1_done) begin
                got = 1'b0;
                chk($sformatf("%s latency", name), 64'(cyc - t_ack), 64'(v.exp_lat));
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                chk($sformatf("%s resp", name),
                    {m1_done, m1_done ? m1_err : m0_err, m1_done ? m1_rdata : m0_rdata}, e);
            end
        end
        chk($sformatf("%s done seen", name), got, 0);
        chk($sformatf("%s write cycles", name), we_cnt, (v.we && !v.exp_err) ? 1 : 0);
        if (v.we && !v.exp_err) chk($sformatf("%s mem_wd", name), wd, v.exp_wd);
        @(negedge clk);
        chk($sformatf("%s done pulse", name), m0_done | m1_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t z;
        int n_wait, n_ack, n_done;
        logic dropped, got;
        logic [33:0] e;
        int ack_cyc_q [$];

        z = mk(0, 0, SIZE_B, 0, 0, 0, 0, 0, 0);
        set_req(0, 0, z);
        set_req(1, 0, z);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        m0_req = 1'b1;
        #1;
        chk("reset m0_ack", m0_ack, 0);
        chk("reset done/err", {m0_done, m0_err, m1_done, m1_err, m1_ack}, 0);
        chk("reset rdata", {m0_rdata, m1_rdata}, 0);
        chk("reset mem port", {mem_addr, mem_wd}, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset state", dbg_state, ST_IDLE);
        m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back(mk(0, 0, SIZE_W, 0, 32'd0,   0, 0, 32'h44332211, 0));
        vecs.push_back(mk(0, 1, SIZE_B, 0, 32'd1,   32'hAB, 0, 0, 32'h4433AB11));
        vecs.push_back(mk(1, 0, SIZE_W, 0, 32'd0,   0, 0, 32'h4433AB11, 0));
        vecs.push_back(mk(1, 0, SIZE_B, 1, 32'd4,   0, 0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 0, SIZE_B, 0, 32'd4,   0, 0, 32'h00000080, 0));
        vecs.push_back(mk(0, 0, SIZE_H, 1, 32'd4,   0, 0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(1, 0, SIZE_H, 0, 32'd4,   0, 0, 32'h0000FF80, 0));
        vecs.push_back(mk(0, 0, SIZE_H, 1, 32'd6,   0, 0, 32'h0000017F, 0));
        vecs.push_back(mk(1, 1, SIZE_H, 0, 32'd6,   32'h1234BEEF, 0, 0, 32'hBEEFFF80));
        vecs.push_back(mk(0, 0, SIZE_W, 1, 32'd4,   0, 0, 32'hBEEFFF80, 0));
        vecs.push_back(mk(0, 0, SIZE_B, 1, 32'd7,   0, 0, 32'hFFFFFFBE, 0));
        vecs.push_back(mk(0, 1, SIZE_W, 0, 32'd8,   32'hCAFEF00D, 0, 0, 32'hCAFEF00D));
        vecs.push_back(mk(1, 0, SIZE_B, 0, 32'd9,   0, 0, 32'h000000F0, 0));
        vecs.push_back(mk(0, 0, SIZE_H, 1, 32'd10,  0, 0, 32'hFFFFCAFE, 0));
        vecs.push_back(mk(0, 0, SIZE_W, 0, 32'd252, 0, 0, 32'hFFFEFDFC, 0));
        vecs.push_back(mk(1, 1, SIZE_B, 0, 32'd255, 32'hFFFFFF5A, 0, 0, 32'h5AFEFDFC));
        vecs.push_back(mk(0, 0, SIZE_B, 1, 32'd255, 0, 0, 32'h0000005A, 0));
        vecs.push_back(mk(0, 0, SIZE_H, 0, 32'd1,   0, 1, 0, 0));
        vecs.push_back(mk(1, 0, SIZE_W, 0, 32'd2,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, SIZE_RSV, 0, 32'd0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, SIZE_B, 0, 32'd256, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, SIZE_W, 0, 32'h100, 32'h55555555, 1, 0, 0));
        vecs.push_back(mk(0, 1, SIZE_B, 0, 32'hFFFFFFFF, 32'h77, 1, 0, 0));
        vecs.push_back(mk(1, 1, SIZE_H, 0, 32'd3,   32'h9999, 1, 0, 0));
        vecs.push_back(mk(0, 0, SIZE_W, 0, 32'd0,   0, 0, 32'h4433AB11, 0));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i), n_wait);

        // Both requesters held after a fresh reset: m0, m1, m0, m1.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        set_req(0, 1'b1, mk(0, 0, SIZE_W, 0, 32'd0, 0, 0, 0, 0));
        set_req(1, 1'b1, mk(1, 0, SIZE_B, 0, 32'd8, 0, 0, 0, 0));
        n_ack = 0; n_done = 0; dropped = 1'b0;
        for (int i = 0; i < 60 && n_done < 4; i++) begin
            @(negedge clk);
            if (m0_done || m1_done) begin
                n_done++;
                chk("rr expected done", exp_q.size() != 0 && ack_cyc_q.size() != 0, 1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                chk($sformatf("rr resp%0d", n_done),
                    {m1_done, m1_done ? m1_err : m0_err, m1_done ? m1_rdata : m0_rdata}, e);
                if (ack_cyc_q.size() != 0)
                    chk($sformatf("rr latency%0d", n_done), 64'(cyc - ack_cyc_q.pop_front()), 2);
            end
            if (m0_ack || m1_ack) begin
                chk("rr single ack", m0_ack & m1_ack, 0);
                chk($sformatf("rr order%0d", n_ack), m1_ack, 64'(n_ack % 2));
                exp_q.push_back({m1_ack, 1'b0, m1_ack ? 32'h0000000D : 32'h4433AB11});
                ack_cyc_q.push_back(cyc);
                n_ack++;
            end
            if (n_ack == 4 && !dropped) begin
                @(posedge clk); #1;
                m0_req = 1'b0; m1_req = 1'b0;
                dropped = 1'b1;
            end
        end
        chk("rr done count", n_done, 4);

        // Reset during the write cycle of a word store.
        @(posedge clk); #1;
        set_req(0, 1'b1, mk(0, 1, SIZE_W, 0, 32'h20, 32'h12345678, 0, 0, 0));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = m0_ack;
        end
        chk("rstwr ack", got, 1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = mem_we;
        end
        chk("rstwr reached WR", got, 1);
        rst_n = 1'b0;
        #1;
        chk("rstwr mem_we drop", mem_we, 0);
        chk("rstwr state", dbg_state, ST_IDLE);
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = got | m0_done | m1_done;
        end
        chk("rstwr no done", got, 0);
        rst_n = 1'b1;
        run_vec(mk(1, 0, SIZE_W, 0, 32'h20, 0, 0, 32'h23222120, 0), "rstwr m1 load", n_wait);
        chk("rstwr first idle ack", n_wait, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
